// File: rtl/mem_bus_arbiter.sv
// Multi-master byte-bus arbiter: grants one 1-4 byte request at a time, splits it into
// single-byte bus accesses and packs read bytes little-endian into a 32-bit word.
module mem_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned PRIO_MODE      = 0
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*2-1:0]      m_len,
  input  logic [NUM_MASTERS*32-1:0]     m_wdata,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic [31:0]                   m_rdata,
  output logic [ADDR_WIDTH-1:0]         mem_a,
  output logic                          mem_wr,
  output logic [7:0]                    mem_dout,
  input  logic [7:0]                    mem_din,
  output logic                          ram_en,
  output logic                          io_en
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RTAIL, DONE} state_t;

  state_t                 state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          sel;
  logic [IW-1:0]          win;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          start;
  logic                   win_vld;
  logic [ADDR_WIDTH-1:0]  base;
  logic [1:0]             len;
  logic [1:0]             cnt;
  logic                   wr;
  logic [3:0][7:0]        wdata;
  logic [3:0][7:0]        rbuf;
  logic [3:0][7:0]        rdata_nxt;
  logic [NUM_MASTERS-1:0] done_q;
  logic                   mem_wr_q;

  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_MASTERS];
  logic [1:0]             len_arr   [NUM_MASTERS];
  logic [31:0]            wdata_arr [NUM_MASTERS];

  // Unpack the flat per-master request buses
  always_comb begin
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      addr_arr[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      len_arr[i]   = m_len[i*2 +: 2];
      wdata_arr[i] = m_wdata[i*32 +: 32];
    end
  end

  // Winner search: first requester at or after start, wrapping; fixed mode starts at 0
  always_comb begin
    start   = (PRIO_MODE != 0) ? rr_ptr : '0;
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      idx = IW'((int'(start) + k) % int'(NUM_MASTERS));
      if (!win_vld && m_req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Final read word: last byte comes straight off the bus in RTAIL
  always_comb begin
    rdata_nxt      = rbuf;
    rdata_nxt[len] = mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      sel      <= '0;
      base     <= '0;
      len      <= '0;
      cnt      <= '0;
      wr       <= 1'b0;
      wdata    <= '0;
      rbuf     <= '0;
      done_q   <= '0;
      mem_wr_q <= 1'b0;
      mem_a    <= '0;
      mem_dout <= '0;
      m_rdata  <= '0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= XFER;
            sel      <= win;
            base     <= addr_arr[win];
            len      <= len_arr[win];
            wr       <= m_wr[win];
            wdata    <= wdata_arr[win];
            rbuf     <= '0;
            cnt      <= '0;
            mem_a    <= addr_arr[win];
            mem_wr_q <= m_wr[win];
            mem_dout <= wdata_arr[win][7:0];
            if (PRIO_MODE != 0) rr_ptr <= IW'((int'(win) + 1) % int'(NUM_MASTERS));
          end
        end
        XFER: begin
          // Synchronous RAM: data for the previous address arrives now
          if (!wr && cnt != 2'd0) rbuf[cnt - 2'd1] <= mem_din;
          if (cnt == len) begin
            mem_wr_q <= 1'b0;
            if (wr) begin
              state  <= DONE;
              done_q <= NUM_MASTERS'(1) << sel;
              mem_a  <= '0;
            end else begin
              state  <= RTAIL;
            end
          end else begin
            cnt      <= cnt + 2'd1;
            mem_a    <= base + ADDR_WIDTH'(cnt + 2'd1);
            mem_dout <= wdata[cnt + 2'd1];
          end
        end
        RTAIL: begin
          m_rdata <= rdata_nxt;
          state   <= DONE;
          done_q  <= NUM_MASTERS'(1) << sel;
          mem_a   <= '0;
        end
        DONE: begin
          done_q <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A paused bus must never see a write strobe or a completion
  assign mem_wr = mem_wr_q & rdy_in;
  assign m_done = rdy_in ? done_q : '0;

  assign io_en  = (mem_a[RAM_ADDR_WIDTH -: 2] == 2'b11);
  assign ram_en = ~io_en;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fixed-priority DUT on a RAM model plus a
// round-robin twin sharing the same inputs for the arbitration-order check.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [1:0]  m_req;
  logic [1:0]  m_wr;
  logic [63:0] m_addr;
  logic [3:0]  m_len;
  logic [63:0] m_wdata;

  logic [1:0]  m_done,  m_done_r;
  logic [31:0] m_rdata, m_rdata_r;
  logic [31:0] mem_a,   mem_a_r;
  logic        mem_wr,  mem_wr_r;
  logic [7:0]  mem_dout, mem_dout_r;
  logic [7:0]  mem_din, mem_din_r;
  logic        ram_en,  ram_en_r;
  logic        io_en,   io_en_r;

  logic [7:0]  ram [0:131071];
  logic [7:0]  io_last;
  int          io_writes;
  int          wcnt [4];

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .PRIO_MODE(0)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
    .m_done(m_done), .m_rdata(m_rdata),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .ram_en(ram_en), .io_en(io_en)
  );

  mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .PRIO_MODE(1)) dut_rr (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
    .m_done(m_done_r), .m_rdata(m_rdata_r),
    .mem_a(mem_a_r), .mem_wr(mem_wr_r), .mem_dout(mem_dout_r), .mem_din(mem_din_r),
    .ram_en(ram_en_r), .io_en(io_en_r)
  );

  // Synchronous RAM and IO capture; only the fixed-priority DUT may write
  always @(posedge clk) begin
    if (rst) begin
      ram[17'h100] <= 8'h11;
      ram[17'h101] <= 8'h22;
      ram[17'h102] <= 8'h33;
      ram[17'h103] <= 8'h44;
      io_last      <= 8'h00;
      io_writes    <= 0;
      for (int i = 0; i < 4; i++) wcnt[i] <= 0;
    end else begin
      if (mem_wr && ram_en) ram[mem_a[16:0]] <= mem_dout;
      if (mem_wr && io_en) begin
        io_last   <= mem_dout;
        io_writes <= io_writes + 1;
      end
      if (mem_wr && ram_en && mem_a[31:2] == 30'h100) wcnt[mem_a[1:0]] <= wcnt[mem_a[1:0]] + 1;
    end
    mem_din   <= ram[mem_a[16:0]];
    mem_din_r <= ram[mem_a_r[16:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (m_done != 2'b00) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nf, nr, nd;
    int sf[4];
    int sr[4];
    int exp_rr[4];
    logic [7:0] eb[4];

    total = 0;
    bad   = 0;
    rst = 1'b1; rdy = 1'b1;
    m_req = '0; m_wr = '0; m_addr = '0; m_len = '0; m_wdata = '0;
    step();
    step();
    chk("rst_done",  32'(m_done), 32'h0);
    chk("rst_rdata", m_rdata, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_wr",    32'(mem_wr), 32'h0);
    chk("rst_dout",  32'(mem_dout), 32'h0);
    rst = 1'b0;
    step();

    // 1: 4-byte read from RAM
    m_addr[31:0] = 32'h100; m_len[1:0] = 2'd3; m_wr = 2'b00; m_req = 2'b01;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_addr", mem_a, 32'h100 + 32'(k));
    end
    step();
    chk("t1_rtail_nodone", 32'(m_done), 32'h0);
    step();
    chk("t1_done",  32'(m_done), 32'h1);
    chk("t1_rdata", m_rdata, 32'h44332211);
    m_req = 2'b00;
    step();
    chk("t1_pulse", 32'(m_done), 32'h0);

    // 2: 2-byte write by master1 then readback
    m_addr[63:32] = 32'h200; m_len[3:2] = 2'd1; m_wdata[63:32] = 32'h0000BEEF;
    m_wr = 2'b10; m_req = 2'b10;
    step();
    chk("t2_wr0",   32'(mem_wr), 32'h1);
    chk("t2_a0",    mem_a, 32'h200);
    chk("t2_d0",    32'(mem_dout), 32'hEF);
    step();
    chk("t2_wr1",   32'(mem_wr), 32'h1);
    chk("t2_a1",    mem_a, 32'h201);
    chk("t2_d1",    32'(mem_dout), 32'hBE);
    step();
    chk("t2_done",  32'(m_done), 32'h2);
    chk("t2_wr_end", 32'(mem_wr), 32'h0);
    chk("t2_rdata_held", m_rdata, 32'h44332211);
    m_req = 2'b00;
    step();
    m_wr = 2'b00; m_req = 2'b10;
    wait_done(cyc);
    chk("t2_rb_lat",   32'(cyc), 32'd4);
    chk("t2_rb_done",  32'(m_done), 32'h2);
    chk("t2_rb_rdata", m_rdata, 32'h0000BEEF);
    m_req = 2'b00;
    step();

    // 3: both masters request 1-byte reads continuously
    m_addr[31:0] = 32'h100; m_addr[63:32] = 32'h101; m_len = 4'b0000; m_wr = 2'b00;
    m_req = 2'b11;
    nf = 0; nr = 0;
    for (int i = 0; i < 4; i++) begin sf[i] = 9; sr[i] = 9; end
    for (int i = 0; i < 60 && (nf < 4 || nr < 4); i++) begin
      step();
      if (m_done != 2'b00 && nf < 4) begin
        sf[nf] = (m_done == 2'b01) ? 0 : (m_done == 2'b10) ? 1 : 9;
        nf++;
      end
      if (m_done_r != 2'b00 && nr < 4) begin
        sr[nr] = (m_done_r == 2'b01) ? 0 : (m_done_r == 2'b10) ? 1 : 9;
        nr++;
      end
      if (nf >= 4 && nr >= 4) m_req = 2'b00;
    end
    m_req = 2'b00;
    chk("t3_fix_cnt", 32'(nf), 32'd4);
    chk("t3_rr_cnt",  32'(nr), 32'd4);
    exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 0; exp_rr[3] = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_fix_order", 32'(sf[i]), 32'd0);
      chk("t3_rr_order",  32'(sr[i]), 32'(exp_rr[i]));
    end
    chk("t3_fix_rdata", m_rdata, 32'h11);
    chk("t3_rr_rdata",  m_rdata_r, 32'h22);
    step();

    // 4: 4-byte write stalled for 3 cycles on the second byte
    m_addr[31:0] = 32'h400; m_len[1:0] = 2'd3; m_wdata[31:0] = 32'hDDCCBBAA;
    m_wr = 2'b01; m_req = 2'b01;
    step();
    chk("t4_a0", mem_a, 32'h400);
    step();
    rdy = 1'b0;
    #1;
    chk("t4_stall_wr0", 32'(mem_wr), 32'h0);
    chk("t4_stall_a",   mem_a, 32'h401);
    chk("t4_stall_done", 32'(m_done), 32'h0);
    step();
    chk("t4_stall_wr1", 32'(mem_wr), 32'h0);
    step();
    chk("t4_stall_wr2", 32'(mem_wr), 32'h0);
    chk("t4_stall_a2",  mem_a, 32'h401);
    step();
    rdy = 1'b1;
    #1;
    chk("t4_resume_wr", 32'(mem_wr), 32'h1);
    chk("t4_resume_d",  32'(mem_dout), 32'hBB);
    wait_done(cyc);
    chk("t4_lat", 32'(cyc), 32'd3);
    m_req = 2'b00;
    step();
    eb[0] = 8'hAA; eb[1] = 8'hBB; eb[2] = 8'hCC; eb[3] = 8'hDD;
    for (int i = 0; i < 4; i++) begin
      chk("t4_wcnt", 32'(wcnt[i]), 32'd1);
      chk("t4_ram",  32'(ram[17'h400 + 17'(i)]), 32'(eb[i]));
    end

    // 5: single-byte write into the IO region
    m_addr[31:0] = 32'h30004; m_len[1:0] = 2'd0; m_wdata[31:0] = 32'h41;
    m_wr = 2'b01; m_req = 2'b01;
    step();
    chk("t5_io_en",  32'(io_en), 32'h1);
    chk("t5_ram_en", 32'(ram_en), 32'h0);
    chk("t5_a_lo",   32'(mem_a[2:0]), 32'h4);
    chk("t5_dout",   32'(mem_dout), 32'h41);
    chk("t5_wr",     32'(mem_wr), 32'h1);
    step();
    chk("t5_done",   32'(m_done), 32'h1);
    m_req = 2'b00;
    step();
    chk("t5_io_last",   32'(io_last), 32'h41);
    chk("t5_io_writes", 32'(io_writes), 32'd1);

    // 6: reset in the middle of a read, then a clean 1-byte read
    m_addr[31:0] = 32'h100; m_len[1:0] = 2'd3; m_wr = 2'b00; m_req = 2'b01;
    step();
    step();
    chk("t6_a1", mem_a, 32'h101);
    rst = 1'b1;
    step();
    chk("t6_rst_a",     mem_a, 32'h0);
    chk("t6_rst_wr",    32'(mem_wr), 32'h0);
    chk("t6_rst_dout",  32'(mem_dout), 32'h0);
    chk("t6_rst_done",  32'(m_done), 32'h0);
    chk("t6_rst_rdata", m_rdata, 32'h0);
    rst = 1'b0;
    m_req = 2'b00;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (m_done != 2'b00) nd++;
    end
    chk("t6_no_done", 32'(nd), 32'd0);
    m_addr[31:0] = 32'h103; m_len[1:0] = 2'd0; m_req = 2'b01;
    wait_done(cyc);
    chk("t6_lat",   32'(cyc), 32'd3);
    chk("t6_rdata", m_rdata, 32'h44);
    m_req = 2'b00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
